// File: rtl/instr_sequencer.sv
// Four-state fetch/decode/execute sequencer: owns the program counter and
// drives memory strobes and register load enables for a small accumulator CPU.
module instr_sequencer #(
  parameter int AWIDTH = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              HOLD,
  input  logic [2:0]        IR_OPCODE,
  input  logic [AWIDTH-1:0] IR_ADDR,
  input  logic              ACC_ZERO,
  output logic [AWIDTH-1:0] PC,
  output logic              ADDR_SEL,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic              IR_EN,
  output logic              ACC_EN,
  output logic              HALTED
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [AWIDTH-1:0] PC_ONE = AWIDTH'(1);

  logic [1:0]        state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;

  logic is_alu_ld;
  assign is_alu_ld = (IR_OPCODE == OP_ADD) || (IR_OPCODE == OP_AND) ||
                     (IR_OPCODE == OP_XOR) || (IR_OPCODE == OP_LDA);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        pc_d    = pc_q + PC_ONE;
        state_d = (IR_OPCODE == OP_HLT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        // ACC_ZERO only matters here, on the way out of an SKZ
        if (IR_OPCODE == OP_JMP)                pc_d = IR_ADDR;
        else if (IR_OPCODE == OP_SKZ && ACC_ZERO) pc_d = pc_q + PC_ONE;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    if (HOLD) begin
      state_d = state_q;
      pc_d    = pc_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  logic addr_sel_raw, mem_rd_raw, mem_wr_raw, ir_en_raw, acc_en_raw;

  always_comb begin
    addr_sel_raw = 1'b0;
    mem_rd_raw   = 1'b0;
    mem_wr_raw   = 1'b0;
    ir_en_raw    = 1'b0;
    acc_en_raw   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd_raw = 1'b1;
        ir_en_raw  = 1'b1;
      end
      S_EXEC: begin
        if (is_alu_ld) begin
          addr_sel_raw = 1'b1;
          mem_rd_raw   = 1'b1;
          acc_en_raw   = 1'b1;
        end else if (IR_OPCODE == OP_STO) begin
          addr_sel_raw = 1'b1;
          mem_wr_raw   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Strobes are squashed during reset or hold; ADDR_SEL is left as decoded.
  logic strobe_ok;
  assign strobe_ok = RST_N && !HOLD;

  assign PC       = pc_q;
  assign ADDR_SEL = addr_sel_raw;
  assign MEM_RD   = mem_rd_raw && strobe_ok;
  assign MEM_WR   = mem_wr_raw && strobe_ok;
  assign IR_EN    = ir_en_raw  && strobe_ok;
  assign ACC_EN   = acc_en_raw && strobe_ok;
  assign HALTED   = (state_q == S_HALT) && RST_N;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: each task walks one scenario cycle by
// cycle and compares PC and the packed output vector against hand values.
module tb_instr_sequencer;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST_N, HOLD, ACC_ZERO;
  logic [2:0]    IR_OPCODE;
  logic [AW-1:0] IR_ADDR, PC;
  logic          ADDR_SEL, MEM_RD, MEM_WR, IR_EN, ACC_EN, HALTED;

  int tests = 0;
  int fails = 0;

  // {ADDR_SEL, MEM_RD, MEM_WR, IR_EN, ACC_EN, HALTED}
  logic [5:0] outs;
  assign outs = {ADDR_SEL, MEM_RD, MEM_WR, IR_EN, ACC_EN, HALTED};

  localparam logic [5:0] O_FETCH = 6'b010100;
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_ALU   = 6'b110010;
  localparam logic [5:0] O_STO   = 6'b101000;
  localparam logic [5:0] O_HALT  = 6'b000001;
  localparam logic [5:0] NO_SEL  = 6'b011111;

  instr_sequencer #(.AWIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .HOLD(HOLD), .IR_OPCODE(IR_OPCODE),
    .IR_ADDR(IR_ADDR), .ACC_ZERO(ACC_ZERO), .PC(PC), .ADDR_SEL(ADDR_SEL),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .IR_EN(IR_EN), .ACC_EN(ACC_EN),
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one full instruction from FETCH back to FETCH (or into HALT).
  task automatic run_instr(input logic [2:0] op, input logic [AW-1:0] a, input logic z);
    IR_OPCODE = op; IR_ADDR = a; ACC_ZERO = z;
    step(); step(); step();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; HOLD = 1'b0; IR_OPCODE = 3'b101; IR_ADDR = '0; ACC_ZERO = 1'b0;
    step();
    tests++; if (PC !== 5'd0) begin fails++; $display("FAIL reset_pc got %0d exp 0", PC); end
    tests++; if (outs !== O_IDLE) begin fails++; $display("FAIL reset_outs got %b exp %b", outs, O_IDLE); end
    RST_N = 1'b1; #1;
    tests++; if (outs !== O_FETCH) begin fails++; $display("FAIL reset_fetch got %b exp %b", outs, O_FETCH); end
  endtask

  task automatic test_lda_seq();
    IR_OPCODE = 3'b101;
    for (int i = 0; i < 2; i++) begin
      tests++; if (outs !== O_FETCH || PC !== AW'(i)) begin fails++; $display("FAIL lda_fetch%0d got %b pc %0d exp %b pc %0d", i, outs, PC, O_FETCH, i); end
      step();
      tests++; if (outs !== O_IDLE || PC !== AW'(i)) begin fails++; $display("FAIL lda_decode%0d got %b pc %0d exp %b pc %0d", i, outs, PC, O_IDLE, i); end
      step();
      tests++; if (outs !== O_ALU || PC !== AW'(i + 1)) begin fails++; $display("FAIL lda_exec%0d got %b pc %0d exp %b pc %0d", i, outs, PC, O_ALU, i + 1); end
      step();
    end
  endtask

  task automatic test_jmp();
    run_instr(3'b101, '0, 1'b0);
    tests++; if (PC !== 5'd3) begin fails++; $display("FAIL jmp_setup got %0d exp 3", PC); end
    IR_OPCODE = 3'b111; IR_ADDR = 5'h1A;
    step(); step();
    tests++; if (PC !== 5'd4 || (outs & NO_SEL) !== O_IDLE) begin fails++; $display("FAIL jmp_exec got pc %0d outs %b exp pc 4 outs idle", PC, outs); end
    step();
    tests++; if (PC !== 5'h1A || outs !== O_FETCH) begin fails++; $display("FAIL jmp_target got pc %0h outs %b exp 1a %b", PC, outs, O_FETCH); end
  endtask

  task automatic test_skz();
    run_instr(3'b111, 5'd7, 1'b0);
    IR_OPCODE = 3'b001; ACC_ZERO = 1'b0;
    step(); step();
    tests++; if (PC !== 5'd8 || (outs & NO_SEL) !== O_IDLE) begin fails++; $display("FAIL skz_exec got pc %0d outs %b exp pc 8 idle", PC, outs); end
    ACC_ZERO = 1'b1;
    step();
    tests++; if (PC !== 5'd9) begin fails++; $display("FAIL skz_taken got %0d exp 9", PC); end
    run_instr(3'b111, 5'd7, 1'b0);
    IR_OPCODE = 3'b001; ACC_ZERO = 1'b1;
    step(); step();
    ACC_ZERO = 1'b0;
    step();
    tests++; if (PC !== 5'd8) begin fails++; $display("FAIL skz_not_taken got %0d exp 8", PC); end
  endtask

  task automatic test_wrap();
    run_instr(3'b111, 5'd31, 1'b0);
    IR_OPCODE = 3'b010;
    step(); step();
    tests++; if (PC !== 5'd0 || outs !== O_ALU) begin fails++; $display("FAIL wrap_exec got pc %0d outs %b exp 0 %b", PC, outs, O_ALU); end
    step();
    tests++; if (PC !== 5'd0 || outs !== O_FETCH) begin fails++; $display("FAIL wrap_fetch got pc %0d outs %b exp 0 %b", PC, outs, O_FETCH); end
  endtask

  task automatic test_hold_sto();
    IR_OPCODE = 3'b110; IR_ADDR = 5'd3;
    step(); step();
    tests++; if (PC !== 5'd1 || outs !== O_STO) begin fails++; $display("FAIL sto_exec got pc %0d outs %b exp 1 %b", PC, outs, O_STO); end
    HOLD = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (PC !== 5'd1 || outs[4:1] !== 4'b0000) begin fails++; $display("FAIL sto_hold%0d got pc %0d outs %b exp pc 1 strobes 0", i, PC, outs); end
      step();
    end
    HOLD = 1'b0; #1;
    tests++; if (PC !== 5'd1 || outs !== O_STO) begin fails++; $display("FAIL sto_resume got pc %0d outs %b exp 1 %b", PC, outs, O_STO); end
    step();
    tests++; if (PC !== 5'd1 || outs !== O_FETCH) begin fails++; $display("FAIL sto_after got pc %0d outs %b exp 1 %b", PC, outs, O_FETCH); end
  endtask

  task automatic test_reset_priority();
    IR_OPCODE = 3'b101;
    step();
    HOLD = 1'b1; RST_N = 1'b0; #1;
    tests++; if (outs !== O_IDLE) begin fails++; $display("FAIL rstpri_outs got %b exp %b", outs, O_IDLE); end
    step();
    RST_N = 1'b1; HOLD = 1'b0; #1;
    tests++; if (PC !== 5'd0 || outs !== O_FETCH) begin fails++; $display("FAIL rstpri_fetch got pc %0d outs %b exp 0 %b", PC, outs, O_FETCH); end
  endtask

  task automatic test_halt();
    IR_OPCODE = 3'b000;
    step(); step();
    tests++; if (PC !== 5'd1 || outs !== O_HALT) begin fails++; $display("FAIL halt_enter got pc %0d outs %b exp 1 %b", PC, outs, O_HALT); end
    IR_OPCODE = 3'b101; ACC_ZERO = 1'b1;
    step(); step(); step();
    tests++; if (PC !== 5'd1 || outs !== O_HALT) begin fails++; $display("FAIL halt_stay got pc %0d outs %b exp 1 %b", PC, outs, O_HALT); end
    RST_N = 1'b0; #1;
    tests++; if (HALTED !== 1'b0) begin fails++; $display("FAIL halt_rst_force got %b exp 0", HALTED); end
    step();
    RST_N = 1'b1; #1;
    tests++; if (PC !== 5'd0 || outs !== O_FETCH) begin fails++; $display("FAIL halt_exit got pc %0d outs %b exp 0 %b", PC, outs, O_FETCH); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lda_seq();
    test_jmp();
    test_skz();
    test_wrap();
    test_hold_sto();
    test_reset_priority();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
